// File: rtl/csr_op_queue_pkg.sv
// Shared types and default sizing for the CSR operation queue.
// Pure declarations, no logic.
// Consumers import this package for entry layout and default depth.
package csr_op_queue_pkg;

    localparam int unsigned CSR_Q_DEPTH = 2;
    localparam int unsigned CSR_ADDR_W  = 12;
    localparam int unsigned CSR_XLEN    = 64;

    // One buffered CSR operation at the default widths.
    typedef struct packed {
        logic [CSR_ADDR_W-1:0] addr;
        logic [CSR_XLEN-1:0]   wdata;
    } csr_entry_t;

endpackage : csr_op_queue_pkg

// File: rtl/csr_op_queue.sv
// In-order buffer of issued-but-uncommitted CSR ops with head view and address hazard flag.
// Latency: push visible at head the cycle after issue; result echo and hazard are combinational.
// Backpressure: csr_ready_o drops when full unless commit frees a slot the same cycle; dropped ops flag err.
module csr_op_queue
    import csr_op_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = CSR_Q_DEPTH,
    parameter int unsigned ADDR_W = CSR_ADDR_W,
    parameter int unsigned XLEN   = CSR_XLEN,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              csr_valid_i,
    input  logic [ADDR_W-1:0] csr_addr_i,
    input  logic [XLEN-1:0]   csr_wdata_i,
    output logic              csr_ready_o,
    output logic [XLEN-1:0]   csr_result_o,
    input  logic              csr_commit_i,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              csr_head_valid_o,
    output logic              csr_hazard_o,
    output logic [CNT_W-1:0]  csr_count_o,
    output logic              csr_err_o
);

    // Entry layout at this instance's widths.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    entry_t             r_hold;

    logic               w_push;
    logic               w_pop;
    logic               w_err;
    logic               w_head_vld;
    logic [PTR_W-1:0]   w_wr_ptr_inc;
    logic [PTR_W-1:0]   w_rd_ptr_inc;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_hazard;

    assign w_head_vld   = (r_cnt != '0);
    assign csr_ready_o  = (r_cnt < CNT_W'(DEPTH)) || csr_commit_i;
    assign csr_result_o = csr_wdata_i;

    // Handshake decode, pointer wrap and next occupancy; flush suppresses push, pop and errors.
    always_comb begin
        w_push       = csr_valid_i && csr_ready_o && !flush_i;
        w_pop        = csr_commit_i && w_head_vld && !flush_i;
        w_err        = !flush_i && ((csr_commit_i && !w_head_vld) || (csr_valid_i && !csr_ready_o));
        w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
        w_cnt_nxt    = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (w_pop && !w_push) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // Hazard: any pending entry at the issued address, ignoring the head while it retires.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_vld[i] && (r_mem[i].addr == csr_addr_i) &&
                !(csr_commit_i && (PTR_W'(i) == r_rd_ptr))) begin
                w_hazard = 1'b1;
            end
        end
    end

    // Entry array, valid bits, pointers, occupancy, error pulse and last-head snapshot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_err <= w_err;
            // Snapshot keeps the head contents visible once the queue drains.
            if (w_head_vld) begin
                r_hold <= r_mem[r_rd_ptr];
            end
            if (flush_i) begin
                r_vld    <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_pop) begin
                    r_vld[r_rd_ptr] <= 1'b0;
                    r_rd_ptr        <= w_rd_ptr_inc;
                end
                // Push after pop so a full-queue commit+push reuses the freed slot correctly.
                if (w_push) begin
                    r_mem[r_wr_ptr] <= '{addr: csr_addr_i, wdata: csr_wdata_i};
                    r_vld[r_wr_ptr] <= 1'b1;
                    r_wr_ptr        <= w_wr_ptr_inc;
                end
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    assign csr_head_valid_o = w_head_vld;
    assign csr_addr_o       = w_head_vld ? r_mem[r_rd_ptr].addr  : r_hold.addr;
    assign csr_wdata_o      = w_head_vld ? r_mem[r_rd_ptr].wdata : r_hold.wdata;
    assign csr_hazard_o     = w_hazard;
    assign csr_count_o      = r_cnt;
    assign csr_err_o        = r_err;

endmodule : csr_op_queue

// File: tb/tb_csr_op_queue.sv
// Directed self-checking bench for csr_op_queue at DEPTH=2.
// Inputs change on the falling edge; outputs are sampled 2ns later, before the next rising edge.
// A table walks push/full/wrap/hazard/error/flush cases; a hand sequence covers async reset.
module tb_csr_op_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        csr_valid_i;
    logic [11:0] csr_addr_i;
    logic [63:0] csr_wdata_i;
    logic        csr_ready_o;
    logic [63:0] csr_result_o;
    logic        csr_commit_i;
    logic [11:0] csr_addr_o;
    logic [63:0] csr_wdata_o;
    logic        csr_head_valid_o;
    logic        csr_hazard_o;
    logic [1:0]  csr_count_o;
    logic        csr_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    csr_op_queue #(.DEPTH(2), .ADDR_W(12), .XLEN(64)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .csr_valid_i      (csr_valid_i),
        .csr_addr_i       (csr_addr_i),
        .csr_wdata_i      (csr_wdata_i),
        .csr_ready_o      (csr_ready_o),
        .csr_result_o     (csr_result_o),
        .csr_commit_i     (csr_commit_i),
        .csr_addr_o       (csr_addr_o),
        .csr_wdata_o      (csr_wdata_o),
        .csr_head_valid_o (csr_head_valid_o),
        .csr_hazard_o     (csr_hazard_o),
        .csr_count_o      (csr_count_o),
        .csr_err_o        (csr_err_o)
    );

    typedef struct {
        logic        fl;
        logic        v;
        logic [11:0] a;
        logic [63:0] w;
        logic        c;
        logic        rdy;
        logic        hv;
        logic [11:0] ao;
        logic [63:0] wo;
        logic        hz;
        logic [1:0]  cnt;
        logic        err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(logic fl, logic v, logic [11:0] a, logic [63:0] w, logic c,
                                logic rdy, logic hv, logic [11:0] ao, logic [63:0] wo,
                                logic hz, logic [1:0] cnt, logic err);
        vec_t r;
        r.fl = fl; r.v = v; r.a = a; r.w = w; r.c = c;
        r.rdy = rdy; r.hv = hv; r.ao = ao; r.wo = wo; r.hz = hz; r.cnt = cnt; r.err = err;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic fl, logic v, logic [11:0] a, logic [63:0] w, logic c);
        flush_i      = fl;
        csr_valid_i  = v;
        csr_addr_i   = a;
        csr_wdata_i  = w;
        csr_commit_i = c;
    endtask

    initial begin
        //             fl v  addr    wdata  c | rdy hv ao      wo     hz cnt err
        vecs[0]  = mk(0, 0, 12'h000, 64'h0, 0,  1, 0, 12'h000, 64'h0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 12'h300, 64'hA, 0,  1, 0, 12'h000, 64'h0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 12'h341, 64'hB, 0,  1, 1, 12'h300, 64'hA, 0, 1, 0);
        vecs[3]  = mk(0, 0, 12'h341, 64'h0, 0,  0, 1, 12'h300, 64'hA, 1, 2, 0);
        vecs[4]  = mk(0, 0, 12'h300, 64'h0, 0,  0, 1, 12'h300, 64'hA, 1, 2, 0);
        vecs[5]  = mk(0, 1, 12'h305, 64'hC, 1,  1, 1, 12'h300, 64'hA, 0, 2, 0);
        vecs[6]  = mk(0, 0, 12'h341, 64'h0, 1,  1, 1, 12'h341, 64'hB, 0, 2, 0);
        vecs[7]  = mk(0, 0, 12'h305, 64'h0, 0,  1, 1, 12'h305, 64'hC, 1, 1, 0);
        vecs[8]  = mk(0, 0, 12'h000, 64'h0, 1,  1, 1, 12'h305, 64'hC, 0, 1, 0);
        vecs[9]  = mk(0, 0, 12'h000, 64'h0, 1,  1, 0, 12'h305, 64'hC, 0, 0, 0);
        vecs[10] = mk(0, 0, 12'h000, 64'h0, 0,  1, 0, 12'h305, 64'hC, 0, 0, 1);
        vecs[11] = mk(0, 0, 12'h000, 64'h0, 0,  1, 0, 12'h305, 64'hC, 0, 0, 0);
        vecs[12] = mk(0, 1, 12'h310, 64'hD, 0,  1, 0, 12'h305, 64'hC, 0, 0, 0);
        vecs[13] = mk(0, 1, 12'h311, 64'hE, 0,  1, 1, 12'h310, 64'hD, 0, 1, 0);
        vecs[14] = mk(0, 1, 12'h312, 64'hF, 0,  0, 1, 12'h310, 64'hD, 0, 2, 0);
        vecs[15] = mk(0, 0, 12'h000, 64'h0, 0,  0, 1, 12'h310, 64'hD, 0, 2, 1);
        vecs[16] = mk(1, 1, 12'h313, 64'h1, 0,  0, 1, 12'h310, 64'hD, 0, 2, 0);
        vecs[17] = mk(0, 0, 12'h000, 64'h0, 0,  1, 0, 12'h310, 64'hD, 0, 0, 0);
        vecs[18] = mk(0, 1, 12'h320, 64'h2, 0,  1, 0, 12'h310, 64'hD, 0, 0, 0);
        vecs[19] = mk(0, 0, 12'h320, 64'h0, 0,  1, 1, 12'h320, 64'h2, 1, 1, 0);

        rst_i = 1'b1;
        drive(0, 0, 12'h000, 64'h0, 0);
        repeat (2) @(negedge clk_i);
        #2;
        chk("rst_ready", csr_ready_o, 1);
        chk("rst_head_valid", csr_head_valid_o, 0);
        chk("rst_count", csr_count_o, 0);
        chk("rst_addr", csr_addr_o, 0);
        chk("rst_wdata", csr_wdata_o, 0);
        chk("rst_err", csr_err_o, 0);
        chk("rst_hazard", csr_hazard_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            drive(vecs[i].fl, vecs[i].v, vecs[i].a, vecs[i].w, vecs[i].c);
            #2;
            chk($sformatf("v%0d_ready", i), csr_ready_o, vecs[i].rdy);
            chk($sformatf("v%0d_head_valid", i), csr_head_valid_o, vecs[i].hv);
            chk($sformatf("v%0d_addr", i), csr_addr_o, vecs[i].ao);
            chk($sformatf("v%0d_wdata", i), csr_wdata_o, vecs[i].wo);
            chk($sformatf("v%0d_hazard", i), csr_hazard_o, vecs[i].hz);
            chk($sformatf("v%0d_count", i), csr_count_o, vecs[i].cnt);
            chk($sformatf("v%0d_err", i), csr_err_o, vecs[i].err);
            chk($sformatf("v%0d_result", i), csr_result_o, vecs[i].w);
        end

        // Async reset asserted mid-cycle while a push is presented with one entry pending.
        @(negedge clk_i);
        drive(0, 1, 12'h331, 64'h5, 0);
        #1;
        chk("pre_rst_count", csr_count_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("async_rst_count", csr_count_o, 0);
        chk("async_rst_head_valid", csr_head_valid_o, 0);
        chk("async_rst_ready", csr_ready_o, 1);
        chk("async_rst_addr", csr_addr_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(0, 0, 12'h000, 64'h0, 0);
        @(negedge clk_i);
        #2;
        chk("post_rst_count", csr_count_o, 0);
        chk("post_rst_err", csr_err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_csr_op_queue
